riscv_multicycle_ctrl: RTL

Parametrised multicycle control unit for the minimal RISC-V core. It drives the existing simple datapath through IF/ID/EX/MEM/WB with ready/valid handshakes on instruction and data memory. Non-memory instructions bypass the MEM state. It adds the full branch set, an illegal-instruction trap and a bounded memory-wait timeout with a sticky error state.

---
 rtl/riscv_ctrl_pkg.sv | 62 ++++++
 rtl/riscv_alu_decode.sv | 39 +++
 rtl/riscv_multicycle_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: opcodes, funct fields,
// ALU operation codes, FSM states and trap causes.
package riscv_ctrl_pkg;

   localparam logic [6:0] rTYPE  = 7'b0110011;
   localparam logic [6:0] iTYPE  = 7'b0010011;
   localparam logic [6:0] ilTYPE = 7'b0000011;
   localparam logic [6:0] sTYPE  = 7'b0100011;
   localparam logic [6:0] bTYPE  = 7'b1100011;

   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   localparam logic [2:0] FUNCT3_ADD  = 3'b000;
   localparam logic [2:0] FUNCT3_SLL  = 3'b001;
   localparam logic [2:0] FUNCT3_SLT  = 3'b010;
   localparam logic [2:0] FUNCT3_XOR  = 3'b100;
   localparam logic [2:0] FUNCT3_SR   = 3'b101;
   localparam logic [2:0] FUNCT3_OR   = 3'b110;
   localparam logic [2:0] FUNCT3_AND  = 3'b111;

   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;

   localparam logic [3:0] ALUOP_ADD = 4'd0;
   localparam logic [3:0] ALUOP_SUB = 4'd1;
   localparam logic [3:0] ALUOP_AND = 4'd2;
   localparam logic [3:0] ALUOP_OR  = 4'd3;
   localparam logic [3:0] ALUOP_XOR = 4'd4;
   localparam logic [3:0] ALUOP_SLT = 4'd5;
   localparam logic [3:0] ALUOP_SLL = 4'd6;
   localparam logic [3:0] ALUOP_SRL = 4'd7;
   localparam logic [3:0] ALUOP_SRA = 4'd8;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_ERR = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_ILLEGAL  = 2'd1,
      CAUSE_FETCH_TO = 2'd2,
      CAUSE_DATA_TO  = 2'd3
   } err_cause_e;

   // Branches with funct3 010/011 have no defined condition and are treated as illegal.
   function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
      logic known;
      known = (opcode == rTYPE) || (opcode == iTYPE) || (opcode == ilTYPE) ||
              (opcode == sTYPE) || (opcode == bTYPE);
      return known && !((opcode == bTYPE) && (funct3[2:1] == 2'b01));
   endfunction

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational ALU operation and operand-select decode, shared between core variants.
module riscv_alu_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [3:0] alu_ctrl_o,
   output logic       alu_src_o
);

   logic alt;

   assign alt       = (funct7_i == FUNCT7_ALT);
   assign alu_src_o = !((opcode_i == rTYPE) || (opcode_i == bTYPE));

   always_comb begin
      alu_ctrl_o = ALUOP_ADD;
      case (opcode_i)
         ilTYPE, sTYPE: alu_ctrl_o = ALUOP_ADD;
         bTYPE:         alu_ctrl_o = ALUOP_SUB;
         rTYPE, iTYPE: begin
            case (funct3_i)
               // Immediate adds carry no funct7, so only register ops may select SUB.
               FUNCT3_ADD: alu_ctrl_o = (opcode_i == rTYPE && alt) ? ALUOP_SUB : ALUOP_ADD;
               FUNCT3_SLL: alu_ctrl_o = ALUOP_SLL;
               FUNCT3_SLT: alu_ctrl_o = ALUOP_SLT;
               FUNCT3_XOR: alu_ctrl_o = ALUOP_XOR;
               FUNCT3_SR:  alu_ctrl_o = alt ? ALUOP_SRA : ALUOP_SRL;
               FUNCT3_OR:  alu_ctrl_o = ALUOP_OR;
               FUNCT3_AND: alu_ctrl_o = ALUOP_AND;
               default:    alu_ctrl_o = ALUOP_ADD;
            endcase
         end
         default: alu_ctrl_o = ALUOP_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM (IF/ID/EX/MEM/WB) with ready/valid memory waits, branch
// resolution, illegal-opcode trap, bounded wait timeout and a sticky error state.
module riscv_multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter bit          SKIP_MEM     = 1'b1,
   parameter int unsigned RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             instruction,
   input  logic                    iReady,
   input  logic                    dReady,
   input  logic                    Zero,
   input  logic                    LessS,
   input  logic                    LessU,
   output logic                    iReq,
   output logic                    IRWrite,
   output logic [3:0]              ALUCtrl,
   output logic                    ALUSrc,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    MemtoReg,
   output logic                    RegWrite,
   output logic                    loadPC,
   output logic                    PCSrc,
   output logic [2:0]              state,
   output logic                    error,
   output logic [1:0]              err_cause,
   output logic [RETIRE_CNT_W-1:0] retired
);

   localparam int unsigned      CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e                  state_q, state_d;
   err_cause_e              cause_q, cause_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [RETIRE_CNT_W-1:0] retired_q, retired_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load, is_store, is_branch, is_mem;
   logic       br_taken, timeout_hit;
   logic       unused_instr_bits;

   assign opcode            = instruction[6:0];
   assign funct3            = instruction[14:12];
   assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};
   assign is_load           = (opcode == ilTYPE);
   assign is_store          = (opcode == sTYPE);
   assign is_branch         = (opcode == bTYPE);
   assign is_mem            = is_load || is_store;
   assign timeout_hit       = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);

   riscv_alu_decode u_alu_decode (
      .opcode_i   (opcode),
      .funct3_i   (funct3),
      .funct7_i   (instruction[31:25]),
      .alu_ctrl_o (ALUCtrl),
      .alu_src_o  (ALUSrc)
   );

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         FUNCT3_BEQ:  br_taken = Zero;
         FUNCT3_BNE:  br_taken = !Zero;
         FUNCT3_BLT:  br_taken = LessS;
         FUNCT3_BGE:  br_taken = !LessS;
         FUNCT3_BLTU: br_taken = LessU;
         FUNCT3_BGEU: br_taken = !LessU;
         default:     br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         cause_q   <= CAUSE_NONE;
         cnt_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         cnt_q     <= cnt_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      cnt_d     = '0;
      retired_d = retired_q;
      iReq      = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      loadPC    = 1'b0;
      PCSrc     = 1'b0;
      case (state_q)
         S_IF: begin
            iReq = 1'b1;
            if (iReady) begin
               IRWrite = 1'b1;
               state_d = S_ID;
            end else if (timeout_hit) begin
               state_d = S_ERR;
               cause_d = CAUSE_FETCH_TO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ID: begin
            if (is_legal(opcode, funct3)) begin
               state_d = S_EX;
            end else begin
               state_d = S_ERR;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EX: state_d = (is_mem || !SKIP_MEM) ? S_MEM : S_WB;
         S_MEM: begin
            MemRead  = is_load;
            MemWrite = is_store;
            if (!is_mem || dReady) begin
               state_d = S_WB;
            end else if (timeout_hit) begin
               state_d = S_ERR;
               cause_d = CAUSE_DATA_TO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            loadPC    = 1'b1;
            RegWrite  = !(is_store || is_branch);
            MemtoReg  = is_load;
            PCSrc     = is_branch && br_taken;
            retired_d = retired_q + RETIRE_CNT_W'(1);
            state_d   = S_IF;
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IF;
      endcase
      // Reset silences every strobe in the same cycle, not only from the next one.
      if (rst) begin
         iReq     = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         MemtoReg = 1'b0;
         RegWrite = 1'b0;
         loadPC   = 1'b0;
         PCSrc    = 1'b0;
      end
   end

   assign state     = state_q;
   assign error     = (state_q == S_ERR) && !rst;
   assign err_cause = rst ? '0 : cause_q;
   assign retired   = retired_q;

endmodule
